blake2_g_iter: RTL and testbench

//  Iterative, registered BLAKE2 G mixing unit for both BLAKE2b (64-bit words) and BLAKE2s (32-bit words).
//  It successor-replaces the purely combinational G stage where timing or area demands a multicycle G.

---
 rtl/blake2_g_iter.sv | 148 ++++++++++++++
 tb/tb_blake2_g_iter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/blake2_g_iter.sv
// Multicycle BLAKE2 G mixing unit (BLAKE2b for 64-bit words, BLAKE2s for 32-bit words).
// Operands are captured on start/ready, mixed over 4 (or 2) cycles, and the result is published with a done pulse.
module blake2_g_iter #(
    parameter int WORD_WIDTH     = 64,
    parameter int HALVES_PER_CYC = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  ready,
    output logic                  done,
    input  logic [WORD_WIDTH-1:0] a,
    input  logic [WORD_WIDTH-1:0] b,
    input  logic [WORD_WIDTH-1:0] c,
    input  logic [WORD_WIDTH-1:0] d,
    input  logic [WORD_WIDTH-1:0] m0,
    input  logic [WORD_WIDTH-1:0] m1,
    output logic [WORD_WIDTH-1:0] a_prim,
    output logic [WORD_WIDTH-1:0] b_prim,
    output logic [WORD_WIDTH-1:0] c_prim,
    output logic [WORD_WIDTH-1:0] d_prim
);

    localparam int R1 = (WORD_WIDTH == 32) ? 16 : 32;
    localparam int R2 = (WORD_WIDTH == 32) ? 12 : 24;
    localparam int R3 = (WORD_WIDTH == 32) ? 8  : 16;
    localparam int R4 = (WORD_WIDTH == 32) ? 7  : 63;

    localparam logic [1:0] STEP_INC  = 2'(HALVES_PER_CYC);
    localparam logic [1:0] STEP_LAST = 2'(4 - HALVES_PER_CYC);

    typedef struct packed {
        logic [WORD_WIDTH-1:0] a;
        logic [WORD_WIDTH-1:0] b;
        logic [WORD_WIDTH-1:0] c;
        logic [WORD_WIDTH-1:0] d;
    } g_state_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [1:0]            step_q;
    g_state_t              work_q;
    logic [WORD_WIDTH-1:0] m0_q, m1_q;
    g_state_t              half1, half2;
    logic                  accept;
    logic                  last_step;

    function automatic logic [WORD_WIDTH-1:0] rotr(input logic [WORD_WIDTH-1:0] x, input int n);
        return (x >> n) | (x << (WORD_WIDTH - n));
    endfunction

    // One G half-step; the second operation of each step sees the word updated by the first.
    function automatic g_state_t half_step(input g_state_t s, input logic [1:0] idx,
                                           input logic [WORD_WIDTH-1:0] w0,
                                           input logic [WORD_WIDTH-1:0] w1);
        g_state_t r;
        r = s;
        case (idx)
            2'd0: begin
                r.a = s.a + s.b + w0;
                r.d = rotr(s.d ^ r.a, R1);
            end
            2'd1: begin
                r.c = s.c + s.d;
                r.b = rotr(s.b ^ r.c, R2);
            end
            2'd2: begin
                r.a = s.a + s.b + w1;
                r.d = rotr(s.d ^ r.a, R3);
            end
            default: begin
                r.c = s.c + s.d;
                r.b = rotr(s.b ^ r.c, R4);
            end
        endcase
        return r;
    endfunction

    always_comb begin
        half1 = half_step(work_q, step_q, m0_q, m1_q);
        half2 = (HALVES_PER_CYC == 2) ? half_step(half1, step_q + 2'd1, m0_q, m1_q) : half1;
    end

    assign accept    = (state_q == IDLE) && start;
    assign last_step = (state_q == RUN) && (step_q == STEP_LAST);

    always_comb begin
        state_d = state_q;
        ready   = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                ready = 1'b1;
                if (start) state_d = RUN;
            end
            RUN: begin
                if (last_step) state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and published results; reset aborts any computation in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            step_q  <= 2'd0;
            a_prim  <= '0;
            b_prim  <= '0;
            c_prim  <= '0;
            d_prim  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                step_q <= 2'd0;
            end else if (state_q == RUN) begin
                step_q <= step_q + STEP_INC;
            end
            if (last_step) begin
                a_prim <= half2.a;
                b_prim <= half2.b;
                c_prim <= half2.c;
                d_prim <= half2.d;
            end
        end
    end

    // Working words never leak to the ports, so they need no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            work_q <= '{a: a, b: b, c: c, d: d};
            m0_q   <= m0;
            m1_q   <= m1;
        end else if (state_q == RUN) begin
            work_q <= half2;
        end
    end

endmodule

// File: tb/tb_blake2_g_iter.sv
// Directed bench for blake2_g_iter: BLAKE2b (1 and 2 half-steps/cycle) and BLAKE2s instances.
module tb_blake2_g_iter;

    logic        tb_clk;
    logic        reset;
    logic        start64, start_b2, start32;
    logic [63:0] a64, b64, c64, d64, m064, m164;
    logic [31:0] a32, b32, c32, d32, m032, m132;

    logic        r1, dn1, r2, dn2, r3, dn3;
    logic [63:0] ap1, bp1, cp1, dp1, ap2, bp2, cp2, dp2;
    logic [31:0] ap3, bp3, cp3, dp3;

    int checks   = 0;
    int failures = 0;
    int lat1, lat2, n1, n2, rdy1, rdy2, busy1;

    blake2_g_iter #(.WORD_WIDTH(64), .HALVES_PER_CYC(1)) u_b1 (
        .clk(tb_clk), .reset(reset), .start(start64), .ready(r1), .done(dn1),
        .a(a64), .b(b64), .c(c64), .d(d64), .m0(m064), .m1(m164),
        .a_prim(ap1), .b_prim(bp1), .c_prim(cp1), .d_prim(dp1)
    );

    blake2_g_iter #(.WORD_WIDTH(64), .HALVES_PER_CYC(2)) u_b2 (
        .clk(tb_clk), .reset(reset), .start(start_b2), .ready(r2), .done(dn2),
        .a(a64), .b(b64), .c(c64), .d(d64), .m0(m064), .m1(m164),
        .a_prim(ap2), .b_prim(bp2), .c_prim(cp2), .d_prim(dp2)
    );

    blake2_g_iter #(.WORD_WIDTH(32), .HALVES_PER_CYC(1)) u_s (
        .clk(tb_clk), .reset(reset), .start(start32), .ready(r3), .done(dn3),
        .a(a32), .b(b32), .c(c32), .d(d32), .m0(m032), .m1(m132),
        .a_prim(ap3), .b_prim(bp3), .c_prim(cp3), .d_prim(dp3)
    );

    initial tb_clk = 1'b0;
    always #5 tb_clk = ~tb_clk;

    task automatic tick;
        @(posedge tb_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set64(input logic [63:0] a, b, c, d, m0, m1);
        a64 = a; b64 = b; c64 = c; d64 = d; m064 = m0; m164 = m1;
    endtask

    // Issue one start to the 64-bit units and watch them for a bounded window.
    task automatic run_b(input bit use_b2);
        start64  = 1'b1;
        start_b2 = use_b2;
        tick;
        start64  = 1'b0;
        start_b2 = 1'b0;
        lat1 = 0; lat2 = 0; n1 = 0; n2 = 0; rdy1 = -1; rdy2 = -1; busy1 = -1;
        for (int i = 1; i <= 8; i++) begin
            tick;
            if (i == 1) busy1 = int'(r1);
            if (lat1 != 0 && i == lat1 + 1) rdy1 = int'(r1);
            if (lat2 != 0 && i == lat2 + 1) rdy2 = int'(r2);
            if (dn1) begin n1++; if (lat1 == 0) lat1 = i; end
            if (dn2) begin n2++; if (lat2 == 0) lat2 = i; end
        end
    endtask

    task automatic run_s;
        start32 = 1'b1;
        tick;
        start32 = 1'b0;
        lat1 = 0; n1 = 0; rdy1 = -1;
        for (int i = 1; i <= 8; i++) begin
            tick;
            if (lat1 != 0 && i == lat1 + 1) rdy1 = int'(r3);
            if (dn3) begin n1++; if (lat1 == 0) lat1 = i; end
        end
    endtask

    initial begin
        reset = 1'b1; start64 = 1'b1; start_b2 = 1'b1; start32 = 1'b1;
        set64('0, '0, '0, '0, '0, '0);
        a32 = '0; b32 = '0; c32 = '0; d32 = '0; m032 = '0; m132 = '0;
        tick;
        tick;
        // Reset state, with start held high to show reset wins.
        check("rst_ready64", {63'd0, r1}, 64'd1);
        check("rst_done64", {63'd0, dn1}, 64'd0);
        check("rst_prim64", ap1 | bp1 | cp1 | dp1, 64'd0);
        check("rst_ready_h2", {63'd0, r2}, 64'd1);
        check("rst_ready32", {63'd0, r3}, 64'd1);
        check("rst_prim32", {32'd0, ap3 | bp3 | cp3 | dp3}, 64'd0);
        start64 = 1'b0; start_b2 = 1'b0; start32 = 1'b0;
        reset = 1'b0;
        tick;

        // BLAKE2b vector at both step rates.
        set64(64'h6a09e667f2bdc948, 64'h510e527fade682d1, 64'h6a09e667f3bcc908,
              64'h510e527fade68251, 64'd0, 64'd0);
        run_b(1'b1);
        check("b1_latency", 64'(lat1), 64'd4);
        check("b1_ready_in_run", 64'(busy1), 64'd0);
        check("b1_pulses", 64'(n1), 64'd1);
        check("b1_a", ap1, 64'hf0c9aa0de38b1b89);
        check("b1_b", bp1, 64'hbbdf863401fde49b);
        check("b1_c", cp1, 64'he85eb23c42183d3d);
        check("b1_d", dp1, 64'h7111fd8b6445099d);
        check("b2_latency", 64'(lat2), 64'd2);
        check("b2_pulses", 64'(n2), 64'd1);
        check("b2_a", ap2, 64'hf0c9aa0de38b1b89);
        check("b2_b", bp2, 64'hbbdf863401fde49b);
        check("b2_c", cp2, 64'he85eb23c42183d3d);
        check("b2_d", dp2, 64'h7111fd8b6445099d);

        // BLAKE2s single-bit vector.
        a32 = 32'h00000001;
        run_s;
        check("s_latency", 64'(lat1), 64'd4);
        check("s_a", {32'd0, ap3}, 64'h00000011);
        check("s_b", {32'd0, bp3}, 64'h20220202);
        check("s_c", {32'd0, cp3}, 64'h11010100);
        check("s_d", {32'd0, dp3}, 64'h11000100);

        // All-zero inputs on both widths.
        a32 = '0;
        run_s;
        check("s0_prim", {32'd0, ap3 | bp3 | cp3 | dp3}, 64'd0);
        check("s0_pulses", 64'(n1), 64'd1);
        check("s0_ready_after", 64'(rdy1), 64'd1);
        set64('0, '0, '0, '0, '0, '0);
        run_b(1'b1);
        check("b0_prim", ap1 | bp1 | cp1 | dp1, 64'd0);
        check("b0_pulses", 64'(n1), 64'd1);
        check("b0_ready_after", 64'(rdy1), 64'd1);
        check("b0h2_prim", ap2 | bp2 | cp2 | dp2, 64'd0);
        check("b0h2_ready_after", 64'(rdy2), 64'd1);

        // Inputs churn and start pulses while busy, including during DONE.
        set64(64'h6a09e667f2bdc948, 64'h510e527fade682d1, 64'h6a09e667f3bcc908,
              64'h510e527fade68251, 64'd0, 64'd0);
        start64 = 1'b1;
        tick;
        n1 = 0;
        for (int i = 1; i <= 5; i++) begin
            set64({$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
                  {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom});
            start64 = 1'b1;
            tick;
            if (dn1) n1++;
        end
        check("churn_ready_after_done", {63'd0, r1}, 64'd1);
        start64 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick;
            if (dn1) n1++;
        end
        check("churn_pulses", 64'(n1), 64'd1);
        check("churn_a", ap1, 64'hf0c9aa0de38b1b89);
        check("churn_b", bp1, 64'hbbdf863401fde49b);
        check("churn_c", cp1, 64'he85eb23c42183d3d);
        check("churn_d", dp1, 64'h7111fd8b6445099d);

        // Abort with reset two cycles into a run, then a clean run.
        set64(64'h6a09e667f2bdc948, 64'h510e527fade682d1, 64'h6a09e667f3bcc908,
              64'h510e527fade68251, 64'd0, 64'd0);
        start64 = 1'b1;
        tick;
        start64 = 1'b0;
        tick;
        tick;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        check("abort_ready", {63'd0, r1}, 64'd1);
        check("abort_done", {63'd0, dn1}, 64'd0);
        check("abort_prim", ap1 | bp1 | cp1 | dp1, 64'd0);
        n1 = 0;
        for (int i = 0; i < 5; i++) begin
            tick;
            if (dn1) n1++;
        end
        check("abort_no_done", 64'(n1), 64'd0);
        run_b(1'b0);
        check("rerun_latency", 64'(lat1), 64'd4);
        check("rerun_pulses", 64'(n1), 64'd1);
        check("rerun_a", ap1, 64'hf0c9aa0de38b1b89);
        check("rerun_d", dp1, 64'h7111fd8b6445099d);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
